// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests program memory, latches the returned word
// into the instruction register and hands it to the controller over valid/ack.
module instr_fetch_unit #(
   parameter int ADDR_W   = 8,
   parameter int INSTR_W  = 12,
   parameter int RESET_PC = 0,
   parameter int MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_req,
   input  logic [INSTR_W-1:0]   mem_data,
   input  logic                 mem_ready,
   output logic [3:0]           opcode,
   output logic [INSTR_W-5:0]   operand,
   output logic                 instr_valid,
   input  logic                 instr_ack,
   input  logic                 branch_en,
   input  logic [ADDR_W-1:0]    branch_target,
   input  logic                 halt,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted,
   output logic                 fault
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      FETCH,
      VALID,
      HALTED
   } state_t;

   state_t               state;
   logic [INSTR_W-1:0]   ir;
   logic [WAIT_W-1:0]    wait_cnt;

   // NOTE: all state lives in one clocked block using non-blocking assignments,
   // so every branch reads the pre-edge values of pc, wait_cnt and state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= ADDR_W'(RESET_PC);
         ir       <= '0;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir       <= mem_data;
                  pc       <= pc + ADDR_W'(1);
                  wait_cnt <= '0;
                  state    <= VALID;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  // MAX_WAIT-th consecutive non-ready cycle trips the fault
                  if (wait_cnt == WAIT_LAST) begin
                     fault <= 1'b1;
                     state <= HALTED;
                  end
               end
            end
            VALID: begin
               if (instr_ack) begin
                  // Branch still redirects pc when halt wins the state decision
                  if (branch_en) pc <= branch_target;
                  state <= halt ? HALTED : FETCH;
               end
            end
            HALTED: state <= HALTED;
            default: state <= FETCH;
         endcase
      end
   end

   assign mem_req     = (state == FETCH);
   assign instr_valid = (state == VALID);
   assign halted      = (state == HALTED);
   assign mem_addr    = pc;
   assign opcode      = ir[INSTR_W-1 -: 4];
   assign operand     = ir[INSTR_W-5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: a cycle-level spec model drives the
// stimulus and pushes expected instructions; a monitor pops and compares them.
module tb_instr_fetch_unit;

   localparam int MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mem_addr;
   logic        mem_req;
   logic [11:0] mem_data;
   logic        mem_ready;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        instr_valid;
   logic        instr_ack;
   logic        branch_en;
   logic [7:0]  branch_target;
   logic        halt;
   logic [7:0]  pc;
   logic        halted;
   logic        fault;

   instr_fetch_unit #(
      .ADDR_W(8), .INSTR_W(12), .RESET_PC(0), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_ready(mem_ready),
      .opcode(opcode), .operand(operand), .instr_valid(instr_valid), .instr_ack(instr_ack),
      .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
      .pc(pc), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef enum {M_FETCH, M_VALID, M_HALTED} mstate_t;
   typedef struct {
      logic [3:0] op;
      logic [7:0] opnd;
      logic [7:0] pc;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   logic [11:0] mem [256];

   mstate_t     m_state;
   logic [7:0]  m_pc;
   int          m_wait;
   logic        m_fault;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " mem_req"},     32'(mem_req),     32'(m_state == M_FETCH));
      check({tag, " instr_valid"}, 32'(instr_valid), 32'(m_state == M_VALID));
      check({tag, " halted"},      32'(halted),      32'(m_state == M_HALTED));
      check({tag, " fault"},       32'(fault),       32'(m_fault));
      check({tag, " mem_addr"},    32'(mem_addr),    32'(m_pc));
      check({tag, " pc"},          32'(pc),          32'(m_pc));
   endtask

   // One clock cycle: check outputs, apply inputs, advance the model, step the clock.
   task automatic step(input logic rdy, input logic ack, input logic br,
                       input logic [7:0] tgt, input logic hlt, input string tag);
      check_outputs(tag);
      mem_ready     = rdy;
      mem_data      = rdy ? mem[mem_addr] : 12'($urandom);
      instr_ack     = ack;
      branch_en     = br;
      branch_target = tgt;
      halt          = hlt;
      case (m_state)
         M_FETCH: begin
            if (rdy) begin
               exp_q.push_back('{op: mem[m_pc][11:8], opnd: mem[m_pc][7:0], pc: m_pc + 8'd1});
               m_pc   = m_pc + 8'd1;
               m_wait = 0;
               m_state = M_VALID;
            end else begin
               m_wait++;
               if (m_wait == MAX_WAIT) begin
                  m_fault = 1'b1;
                  m_state = M_HALTED;
               end
            end
         end
         M_VALID: begin
            if (ack) begin
               if (br) m_pc = tgt;
               m_state = hlt ? M_HALTED : M_FETCH;
            end
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mem_ready = 1'b0;
      instr_ack = 1'b0;
      branch_en = 1'b0;
      halt      = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_state = M_FETCH;
      m_pc    = 8'h00;
      m_wait  = 0;
      m_fault = 1'b0;
      exp_q.delete();
   endtask

   // Monitor: each newly presented instruction pops one expectation; it is then
   // compared on every cycle it stays valid, which also covers hold stability.
   initial begin
      logic was_valid;
      logic have;
      exp_t cur;
      was_valid = 1'b0;
      have      = 1'b0;
      forever begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            if (!was_valid) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  have = 1'b0;
                  $display("FAIL unexpected instr: got op 0x%0h operand 0x%0h, expected none", opcode, operand);
               end else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               check("ir opcode",  32'(opcode),  32'(cur.op));
               check("ir operand", 32'(operand), 32'(cur.opnd));
               check("ir pc",      32'(pc),      32'(cur.pc));
            end
         end
         was_valid = (instr_valid === 1'b1);
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
      mem[0]        = 12'h3A5;
      mem_data      = '0;
      branch_target = '0;
      rst           = 1'b1;
      mem_ready     = 1'b0;
      instr_ack     = 1'b0;
      branch_en     = 1'b0;
      halt          = 1'b0;
      @(posedge clk);
      do_reset();

      // Zero-wait fetch of 12'h3A5 at address 0
      step(1, 0, 0, 8'h00, 0, "first fetch");
      check("first opcode",  32'(opcode),  32'h3);
      check("first operand", 32'(operand), 32'hA5);
      check("first pc",      32'(pc),      32'h01);

      // Ack held low for five cycles, stray mem_ready ignored
      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0, "hold");
      step(0, 1, 0, 8'h00, 0, "ack after hold");

      // Branch to 0x40
      step(1, 0, 0, 8'h00, 0, "fetch addr 1");
      step(0, 1, 1, 8'h40, 0, "branch ack");
      step(1, 0, 0, 8'h00, 0, "fetch addr 40");
      check("post-branch pc", 32'(pc), 32'h41);

      // Wrap from 0xFF
      step(0, 1, 1, 8'hFF, 0, "branch to ff");
      step(1, 0, 0, 8'h00, 0, "fetch addr ff");
      check("wrap pc", 32'(pc), 32'h00);
      step(0, 1, 0, 8'h00, 0, "ack after wrap");

      // Memory timeout
      do_reset();
      for (int i = 0; i < MAX_WAIT; i++) step(0, 1, 1, 8'h55, 1, "timeout wait");
      check("timeout fault",   32'(fault),   32'h1);
      check("timeout halted",  32'(halted),  32'h1);
      check("timeout mem_req", 32'(mem_req), 32'h0);
      for (int i = 0; i < 4; i++) step(1, 1, 1, 8'h77, 0, "halted ignores");
      do_reset();
      check("reset clears fault", 32'(fault), 32'h0);

      // Halt with simultaneous branch
      step(1, 0, 0, 8'h00, 0, "fetch before halt");
      step(0, 1, 1, 8'h20, 1, "halt+branch ack");
      check("halt pc",     32'(pc),     32'h20);
      check("halt halted", 32'(halted), 32'h1);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h00, 0, "stay halted");

      // Reset mid-wait restarts the wait count
      do_reset();
      for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 0, "pre-reset wait");
      do_reset();
      for (int i = 0; i < MAX_WAIT - 1; i++) step(0, 0, 0, 8'h00, 0, "restarted wait");
      step(1, 0, 0, 8'h00, 0, "fetch after long wait");
      step(0, 1, 0, 8'h00, 0, "ack after long wait");

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         if (m_state == M_HALTED && $urandom_range(0, 3) == 0)
            do_reset();
         else
            step($urandom_range(0, 9) < 6, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, 8'($urandom),
                 $urandom_range(0, 19) == 0, "random");
      end

      check_outputs("final");
      @(negedge clk);
      #1;
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the controller.
- Owns the program counter and drives the program-memory address and request.
- Waits for memory ready, then latches the returned word into an internal instruction register.
- Presents opcode/operand to the controller with a valid/ack handshake. Supports a taken branch, a halt, and a memory-wait timeout fault.

Parameters:
- ADDR_W, 8: PC / memory address width.
- INSTR_W, 12: instruction width; opcode = bits [INSTR_W-1:INSTR_W-4], operand = bits [INSTR_W-5:0].
- RESET_PC, 0: PC value loaded on reset.
- MAX_WAIT, 15: maximum cycles spent in FETCH without mem_ready before a fault; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  program-memory address (= pc).
- mem_req  out  1  fetch request to program memory.
- mem_data  in  INSTR_W  instruction word from memory.
- mem_ready  in  1  mem_data valid this cycle.
- opcode  out  4  IR opcode field, to the controller.
- operand  out  INSTR_W-4  IR operand field.
- instr_valid  out  1  IR holds an instruction not yet consumed.
- instr_ack  in  1  controller consumes the instruction.
- branch_en  in  1  redirect PC; sampled only with the ack.
- branch_target  in  ADDR_W  redirect address.
- halt  in  1  stop fetching; sampled only with the ack.
- pc  out  ADDR_W  current PC.
- halted  out  1  unit is in HALTED.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- rst high at a rising edge, from any state including mid-fetch:
  - state <= FETCH, pc <= RESET_PC, IR <= 0, wait_cnt <= 0, fault <= 0.
  - Resulting outputs: instr_valid=0, halted=0, mem_req=1 in the first cycle after reset.
- States: FETCH, VALID, HALTED. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- mem_req = (state==FETCH); mem_addr = pc at all times.
- FETCH:
  - mem_ready=1: IR <= mem_data; pc <= pc+1, wrapping modulo 2^ADDR_W (max -> 0); wait_cnt <= 0; go VALID. Latency is 1 cycle from a ready edge to instr_valid=1.
  - mem_ready=0: wait_cnt <= wait_cnt+1. If wait_cnt==MAX_WAIT-1: fault <= 1, go HALTED. The fault occurs on the MAX_WAIT-th consecutive non-ready cycle.
- VALID:
  - instr_valid=1; opcode/operand are held stable until ack.
  - instr_ack=0: hold state; IR and pc unchanged.
  - instr_ack=1 and halt=1: go HALTED. halt has priority over branch_en; pc is still updated if branch_en=1.
  - instr_ack=1, halt=0: go FETCH; if branch_en=1, pc <= branch_target, otherwise pc is unchanged (already incremented).
  - Minimum instruction period with zero-wait memory and immediate ack is 2 cycles (FETCH, VALID).
- HALTED:
  - halted=1, mem_req=0, instr_valid=0.
  - IR retains its last value; only rst exits.
- Ignored inputs:
  - mem_ready outside FETCH.
  - instr_ack, branch_en and halt outside VALID.
- Width rules: pc increment is ADDR_W-bit unsigned with no carry out. wait_cnt has width ceil(log2(MAX_WAIT+1)).
- fault is sticky until rst.

Test Plan:
- Reset, then zero-wait memory returning 12'h3A5 at addr 0 -> mem_req=1/mem_addr=0 in cycle 1; in cycle 2 instr_valid=1, opcode=4'h3, operand=8'hA5, pc=1.
- Ack held low for 5 cycles in VALID -> opcode/operand/pc stable, mem_req=0; ack in cycle 6 -> mem_req=1, mem_addr=1 the next cycle.
- Branch: ack with branch_en=1, branch_target=8'h40 -> next FETCH has mem_addr=8'h40; after the fetch, pc=8'h41.
- Wrap: pc=8'hFF, fetch completes -> pc=8'h00 and the next mem_addr=0.
- Timeout: mem_ready held 0 with MAX_WAIT=15 -> after 15 FETCH cycles fault=1, halted=1, mem_req=0; rst for one cycle clears both and fetch restarts at RESET_PC.
- Halt with ack plus simultaneous branch_en (target 8'h20) -> halted=1, pc=8'h20, no further mem_req; rst asserted mid-WAIT (mem_ready=0) -> next cycle pc=0, wait restarted, fault=0.
